// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Architectural register file written by the write-back stage, with two
// combinational read ports for decode and a per-register busy scoreboard
// that tells decode when an operand's producer has issued but not yet
// written back.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   - a same-cycle write-back is forwarded to matching read ports
//               and resolves that port's hazard in the same cycle.
//   undefined - reads show the pre-write value and a same-cycle write-back
//               to a read address still stalls for one more cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset (clears registers and busy bits)
//   wr_en       write-back valid
//   wr_addr     write-back destination register
//   write_data  write-back data
//   rd_addr_a   read port A address
//   rd_addr_b   read port B address
//   rd_use_a    decode consumes port A this cycle
//   rd_use_b    decode consumes port B this cycle
//   rd_data_a   read port A data
//   rd_data_b   read port B data
//   issue_en    instruction with a destination leaves decode
//   issue_dst   that instruction's destination register
//   flush       pipeline flush, clears all busy bits
//   hazard      decode must stall this cycle
//   busy_vec    registered scoreboard bits
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W   = 24,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic                rd_use_a,
    input  logic                rd_use_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic                flush,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic wr_hit_a;
    logic wr_hit_b;
    logic pend_a;
    logic pend_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            // A write-back always commits, even alongside a flush.
            if (wr_en) begin
                regs[wr_addr] <= write_data;
            end

            if (flush) begin
                busy <= '0;
            end else begin
                if (wr_en) begin
                    busy[wr_addr] <= 1'b0;
                end
                // Placed after the clear so a new producer of the same
                // register keeps ownership.
                if (issue_en) begin
                    busy[issue_dst] <= 1'b1;
                end
            end
        end
    end

    assign wr_hit_a = wr_en && (wr_addr == rd_addr_a);
    assign wr_hit_b = wr_en && (wr_addr == rd_addr_b);

`ifdef RF_BYPASS_EN
    assign rd_data_a = wr_hit_a ? write_data : regs[rd_addr_a];
    assign rd_data_b = wr_hit_b ? write_data : regs[rd_addr_b];
    assign pend_a    = busy[rd_addr_a] & ~wr_hit_a;
    assign pend_b    = busy[rd_addr_b] & ~wr_hit_b;
`else
    // Without forwarding the read still sees the old value, so a write in
    // flight to the read address must stall like a busy register.
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign pend_a    = busy[rd_addr_a] | wr_hit_a;
    assign pend_b    = busy[rd_addr_b] | wr_hit_b;
`endif

    assign hazard   = (rd_use_a & pend_a) | (rd_use_b & pend_b);
    assign busy_vec = busy;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Directed testbench for wb_regfile. Inputs change one time unit after the
// rising edge; outputs are sampled a further time unit later, well away
// from the next edge. Expectations depend on RF_BYPASS_EN where the
// forwarding behaviour differs.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int DATA_W   = 24;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    logic                clk;
    logic                rst_n;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   write_data;
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic                rd_use_a;
    logic                rd_use_b;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_dst;
    logic                flush;
    logic                hazard;
    logic [NUM_REGS-1:0] busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    wb_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .write_data (write_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_use_a   (rd_use_a),
        .rd_use_b   (rd_use_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .issue_en   (issue_en),
        .issue_dst  (issue_dst),
        .flush      (flush),
        .hazard     (hazard),
        .busy_vec   (busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_bypass;
`ifdef RF_BYPASS_EN
        exp_bypass = 1'b1;
`else
        exp_bypass = 1'b0;
`endif
        rst_n      = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 3'd3;
        write_data = 24'hABCDEF;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        rd_use_a   = 1'b0;
        rd_use_b   = 1'b0;
        issue_en   = 1'b1;
        issue_dst  = 3'd4;
        flush      = 1'b0;
        tick();
        tick();

        // Reset dominates the concurrent write and issue.
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        issue_en = 1'b0;
        #1;
        check("reset_busy", busy_vec, 32'h0);
        check("reset_hazard", hazard, 32'h0);
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr_a = ADDR_W'(i);
            #1;
            check($sformatf("reset_r%0d", i), rd_data_a, 32'h0);
        end

        // Basic write then read next cycle.
        wr_en = 1'b1; wr_addr = 3'd5; write_data = 24'h123456;
        tick();
        wr_en = 1'b0; rd_addr_a = 3'd5; rd_addr_b = 3'd4;
        #1;
        check("wr_r5", rd_data_a, 32'h123456);
        check("wr_r4_untouched", rd_data_b, 32'h0);

        // Bypass: R2 holds 0x000111, then same-cycle write of 0x00FF00.
        wr_en = 1'b1; wr_addr = 3'd2; write_data = 24'h000111;
        tick();
        write_data = 24'h00FF00; rd_addr_b = 3'd2; rd_use_b = 1'b1;
        #1;
        check("byp_data", rd_data_b, exp_bypass ? 32'h00FF00 : 32'h000111);
        check("byp_hazard", hazard, exp_bypass ? 32'h0 : 32'h1);
        tick();
        wr_en = 1'b0;
        #1;
        check("byp_after_data", rd_data_b, 32'h00FF00);
        check("byp_after_hazard", hazard, 32'h0);
        rd_use_b = 1'b0;

        // Load-use: issue to R6, stall until write-back.
        issue_en = 1'b1; issue_dst = 3'd6;
        #1;
        check("issue_not_yet_busy", busy_vec, 32'h0);
        tick();
        issue_en = 1'b0; rd_addr_a = 3'd6; rd_use_a = 1'b1;
        #1;
        check("lu_hazard", hazard, 32'h1);
        check("lu_busy", busy_vec, 32'h40);
        tick();
        check("lu_hazard_hold", hazard, 32'h1);
        rd_use_a = 1'b0;
        #1;
        check("lu_masked", hazard, 32'h0);
        rd_use_a = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; write_data = 24'h0A0B0C;
        #1;
        check("lu_wb_hazard", hazard, exp_bypass ? 32'h0 : 32'h1);
        tick();
        wr_en = 1'b0;
        #1;
        check("lu_done_hazard", hazard, 32'h0);
        check("lu_done_busy", busy_vec, 32'h0);
        check("lu_done_data", rd_data_a, 32'h0A0B0C);
        rd_use_a = 1'b0;

        // Set/clear collision on R1: set wins, data still commits.
        issue_en = 1'b1; issue_dst = 3'd1;
        tick();
        issue_en = 1'b0;
        #1;
        check("col_pre_busy", busy_vec, 32'h02);
        wr_en = 1'b1; wr_addr = 3'd1; write_data = 24'h55AA33;
        issue_en = 1'b1; issue_dst = 3'd1;
        tick();
        wr_en = 1'b0; issue_en = 1'b0; rd_addr_a = 3'd1;
        #1;
        check("col_busy", busy_vec, 32'h02);
        check("col_data", rd_data_a, 32'h55AA33);
        wr_en = 1'b1; wr_addr = 3'd1; write_data = 24'h55AA34;
        tick();
        wr_en = 1'b0;
        #1;
        check("col_clear", busy_vec, 32'h0);

        // Build busy_vec = 0x2C (R2, R3, R5), then flush with issue and write.
        issue_en = 1'b1;
        issue_dst = 3'd2; tick();
        issue_dst = 3'd3; tick();
        issue_dst = 3'd5; tick();
        issue_en = 1'b0;
        #1;
        check("fl_pre_busy", busy_vec, 32'h2C);
        flush = 1'b1; issue_en = 1'b1; issue_dst = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd7; write_data = 24'h000007;
        tick();
        flush = 1'b0; issue_en = 1'b0; wr_en = 1'b0; rd_addr_b = 3'd7;
        #1;
        check("fl_busy", busy_vec, 32'h0);
        check("fl_r7", rd_data_b, 32'h000007);

        // Mid-run reset clears written data.
        rst_n = 1'b0; rd_addr_a = 3'd5;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst2_r5", rd_data_a, 32'h0);
        check("rst2_r7", rd_data_b, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back consumer of the 24-bit write_data selected in the write-back stage; holds the architectural register file.
- Provides two asynchronous read ports for decode, plus a per-register busy scoreboard.
- Decode uses the scoreboard hazard output to stall on operands whose producer (load, JAL/JALR link, LBI, ALU) has issued but not yet written back.

Parameters:
- DATA_W, 24, register width; matches write_data.
- NUM_REGS, 8, number of architectural registers.
- ADDR_W, 3, register address width; NUM_REGS == 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  write-back valid for this cycle.
- wr_addr  input  ADDR_W  destination register of the write-back.
- write_data  input  DATA_W  write-back data from the write-back select stage.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_use_a  input  1  decode actually consumes port A this cycle.
- rd_use_b  input  1  decode actually consumes port B this cycle.
- rd_data_a  output  DATA_W  port A data.
- rd_data_b  output  DATA_W  port B data.
- issue_en  input  1  instruction with a destination leaves decode this cycle.
- issue_dst  input  ADDR_W  that instruction's destination register.
- flush  input  1  pipeline flush (branch mispredict/exception).
- hazard  output  1  decode must stall this cycle.
- busy_vec  output  NUM_REGS  current scoreboard bits (debug/verification).

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at a rising edge): all registers cleared to 0; all busy bits cleared to 0.
  - Reset takes priority over wr_en, issue_en and flush in the same cycle; in-flight writes are dropped.
- Write: on a rising edge with wr_en=1, regs[wr_addr] <= write_data.
  - All registers, including R0, are writable.
  - Full DATA_W bits; no truncation or extension.
- Read: combinational, rd_data_x = regs[rd_addr_x].
  - With RF_BYPASS_EN, a same-cycle write to the same address is forwarded (see Optional Feature).
- Scoreboard update each rising edge, in this priority:
  1. flush=1: all busy bits cleared. A concurrent wr_en write still commits to the register array; a concurrent issue_en is ignored (the flushed instruction never issues).
  2. Otherwise, clear: wr_en=1 clears busy[wr_addr].
  3. Otherwise, set: issue_en=1 sets busy[issue_dst].
  - Set and clear on the same register in the same cycle: set wins, because the newer producer now owns the register.
  - Write-back to a non-busy register is legal and leaves it 0.
- Hazard (combinational): hazard = (rd_use_a & pend_a) | (rd_use_b & pend_b).
  - pend_x = busy[rd_addr_x], adjusted by the write/bypass rule in Optional Feature.
  - rd_use_x=0 masks its port entirely.
- busy_vec reflects registered state only; it excludes same-cycle write or issue.
- Latency: write-to-read = 0 cycles with bypass, 1 cycle without.
- Scoreboard set to hazard visible: next cycle.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - If wr_en=1 and wr_addr==rd_addr_x, rd_data_x = write_data in the same cycle.
  - pend_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x), so a write-back resolves the hazard in its own cycle.
- Not defined:
  - rd_data_x shows the pre-write register value.
  - pend_x = busy[rd_addr_x] | (wr_en & wr_addr==rd_addr_x), adding one stall cycle.
  - Hazard clears the cycle after the write.

Test Plan:
- Reset: drive rst_n=0 with wr_en=1, wr_addr=3, write_data=0xABCDEF → after release, all registers read 0x000000 and busy_vec=8'h00.
- Basic write/read: write R5=0x123456 → next cycle rd_addr_a=5 reads 0x123456; R4 still 0.
- Bypass: wr_en=1, wr_addr=2, write_data=0x00FF00, rd_addr_b=2, rd_use_b=1 in the same cycle.
  - With RF_BYPASS_EN: rd_data_b=0x00FF00 and hazard=0.
  - Without RF_BYPASS_EN: rd_data_b holds the old value and hazard=1.
- Load-use stall: issue_en, issue_dst=6; next cycle rd_addr_a=6, rd_use_a=1.
  - Result: hazard=1 and busy_vec[6]=1 until wr_en to R6.
  - Repeat with rd_use_a=0 → hazard=0.
- Set/clear collision: busy[1]=1; same cycle wr_en with wr_addr=1 and issue_en with issue_dst=1 → busy_vec[1] remains 1 and R1 holds the written data.
- Flush: busy_vec=8'h2C, then flush=1 with issue_en, issue_dst=0 and wr_en, wr_addr=7, data=0x7 → busy_vec=8'h00 and R7=0x000007.
